// File: rtl/core_pkg.sv
// Shared core types and constants: fetch FSM states, reset/NOP words, opcodes.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    KILL
  } fetch_state_t;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [5:0]  OP_BEQ    = 6'b000100;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instr, pcPlus4, valid.
// Latency: one cycle from load to outputs.
// Backpressure: stall holds contents; flush forces a NOP bubble and wins over stall.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] instrIn,
  input  logic [31:0] pcPlus4In,
  output logic [31:0] instr,
  output logic [31:0] pcPlus4,
  output logic        valid
);
  import core_pkg::*;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr   <= NOP_INSTR;
      pcPlus4 <= '0;
      valid   <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        instr   <= instrIn;
        pcPlus4 <= pcPlus4In;
        valid   <= 1'b1;
      end else begin
        instr   <= NOP_INSTR;
        pcPlus4 <= '0;
        valid   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake, hold buffer, IF/ID register.
// Latency: a word accepted in cycle N appears in IF/ID after the edge ending cycle N.
// Backpressure: stallD parks an accepted word in the hold buffer and stops requests.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = core_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallD,
  input  logic        flush,
  input  logic [31:0] pcBranchD,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemRdata,
  output logic [31:0] instrD,
  output logic [31:0] pcPlus4D,
  output logic        validD
);
  import core_pkg::*;

  fetch_state_t state, stateNext;
  logic [31:0]  reqAddr, reqAddrNext;
  logic [31:0]  pc, pcNext;              // redirect target waiting out a killed request
  logic [31:0]  holdInstr, holdInstrNext;
  logic [31:0]  target, reqAddrPlus4;
  logic [31:0]  ifidInstr, ifidPc4;
  logic         accept, ifidLoad;

  assign target       = word_align(pcBranchD);
  assign reqAddrPlus4 = reqAddr + 32'd4;
  assign imemReq      = (state == REQ) || (state == KILL);
  assign imemAddr     = reqAddr;
  assign accept       = imemReq && imemValid;

  always_comb begin
    stateNext     = state;
    reqAddrNext   = reqAddr;
    pcNext        = pc;
    holdInstrNext = holdInstr;
    ifidLoad      = 1'b0;
    ifidInstr     = imemRdata;
    ifidPc4       = reqAddrPlus4;

    unique case (state)
      IDLE: begin
        stateNext = REQ;
        if (flush) reqAddrNext = target;
      end
      REQ: begin
        if (flush) begin
          if (accept) begin
            reqAddrNext = target;
          end else begin
            pcNext    = target;
            stateNext = KILL;
          end
        end else if (accept) begin
          if (stallD) begin
            holdInstrNext = imemRdata;
            stateNext     = HOLD;
          end else begin
            ifidLoad    = 1'b1;
            reqAddrNext = reqAddrPlus4;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          reqAddrNext = target;
          stateNext   = REQ;
        end else if (!stallD) begin
          ifidLoad    = 1'b1;
          ifidInstr   = holdInstr;
          reqAddrNext = reqAddrPlus4;
          stateNext   = REQ;
        end
      end
      KILL: begin
        // The old address stays on the bus until memory answers; that word is dropped.
        if (flush) pcNext = target;
        if (accept) begin
          reqAddrNext = flush ? target : pc;
          stateNext   = REQ;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (flush) holdInstrNext = NOP_INSTR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      reqAddr   <= RESET_PC;
      pc        <= RESET_PC;
      holdInstr <= NOP_INSTR;
    end else begin
      state     <= stateNext;
      reqAddr   <= reqAddrNext;
      pc        <= pcNext;
      holdInstr <= holdInstrNext;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .stall     (stallD),
    .flush     (flush),
    .load      (ifidLoad),
    .instrIn   (ifidInstr),
    .pcPlus4In (ifidPc4),
    .instr     (instrD),
    .pcPlus4   (pcPlus4D),
    .valid     (validD)
  );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 32-bit pipelined MIPS core.
- Owns the PC and a single-outstanding handshake to instruction memory.
- Feeds the decode stage, where branches resolve and hazard control is produced.
- Consumes the decode-stage `flush` (taken beq) and `stallD` (load-use stall) from hazard control and redirects or holds fetch accordingly.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word (sll $0,$0,0) injected into IF/ID on a flush or bubble.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stallD  input  1  hold IF/ID contents and stop PC advance
- flush  input  1  taken branch in decode; redirect to pcBranchD and squash IF/ID
- pcBranchD  input  32  branch target computed in decode
- imemReq  output  1  request valid to instruction memory
- imemAddr  output  32  word-aligned fetch address, stable while imemReq=1
- imemValid  input  1  response valid; completes the request in the same cycle
- imemRdata  input  32  instruction word, qualified by imemValid
- instrD  output  32  IF/ID instruction
- pcPlus4D  output  32  IF/ID PC+4 of instrD
- validD  output  1  instrD is a real instruction (0 = bubble/NOP)

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - pc=RESET_PC, reqAddr=RESET_PC, state=IDLE.
  - imemReq=0, instrD=NOP_INSTR, pcPlus4D=0, validD=0.
  - Hold buffer empty.
  - Reset asserted mid-request abandons the request; memory must tolerate a dropped request.
- Memory protocol:
  - One request outstanding at a time.
  - imemReq and imemAddr are held stable until the cycle with imemValid=1. That cycle is the accept cycle.
  - imemValid while imemReq=0 is ignored.
  - Zero-wait memory gives one instruction per cycle.
- States:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imemReq=1, imemAddr=reqAddr.
    - On accept with !stallD: instrD←imemRdata, pcPlus4D←reqAddr+4, validD←1, reqAddr←reqAddr+4, stay in REQ.
    - On accept with stallD: word goes to the hold buffer; state←HOLD.
    - No accept and !stallD: instrD←NOP_INSTR, validD←0 (bubble).
    - No accept and stallD: IF/ID unchanged.
  - HOLD: imemReq=0. When !stallD: IF/ID←hold buffer, reqAddr advances by 4, state←REQ.
  - KILL: a flush arrived with a request outstanding and unaccepted. Keep imemReq=1 with the old address. Discard the response on accept, then state←REQ using reqAddr=redirect target.
- Flush (priority over stallD):
  - instrD←NOP_INSTR, validD←0, pcPlus4D←0.
  - Hold buffer cleared.
  - Redirect target is pcBranchD with bits [1:0] forced to 0.
  - REQ with accept in the same cycle: discard the word; reqAddr←target; stay REQ.
  - REQ without accept: pending target latched; state←KILL.
  - HOLD or IDLE: reqAddr←target; state←REQ.
  - Flush while in KILL: the latest target replaces the pending one.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Latency: address presented in cycle N with zero-wait memory → instrD valid after the edge ending cycle N.

Decomposition:
- Shared package core_pkg:
  - fetch_state_t enum {IDLE, REQ, HOLD, KILL}.
  - Constants RESET_PC and NOP_INSTR.
  - beq opcode 6'b000100, shared with decode and hazard logic.
- One natural sub-module: if_id_reg. It holds the instr, pcPlus4 and valid registers with stall-hold and flush-to-NOP priority.
- fetch_stage contains the FSM, PC/target registers and the hold buffer.

Test Plan:
- Reset then zero-wait memory returning addr-as-data → instrD sequence 0x0,0x4,0x8 on consecutive cycles; pcPlus4D 0x4,0x8,0xC; validD=1 from the 3rd cycle after reset release.
- Memory latency 3 cycles → imemAddr stable for 3 cycles; validD=0 bubbles between instructions; no address skipped.
- stallD=1 for 2 cycles coinciding with accept of 0x10 → IF/ID frozen, imemReq=0 in HOLD; after release instrD=word@0x10 then fetch 0x14.
- flush with pcBranchD=0x103 during zero-wait stream → next instrD=NOP_INSTR with validD=0, then fetch from 0x100; the word accepted in the flush cycle is never seen in IF/ID.
- flush mid-latency (request to 0x20 pending) → imemAddr stays 0x20 until imemValid; that word is discarded; next request is to the target.
- Start at PC 0xFFFF_FFFC → next imemAddr 0x0000_0000; flush and stallD together → flush wins.
